// File: rtl/cuckoo_pkg.sv
// Shared encodings and BCD limits for the cuckoo clock time-keeping core.
package cuckoo_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StSetHour  = 2'b01,
        StSetMin   = 2'b10,
        StSetAlarm = 2'b11
    } state_e;

    localparam int unsigned MIN_TENS_MAX = 5;
    localparam int unsigned MIN_WRAP     = MIN_TENS_MAX * 10 + 9;
    localparam int unsigned HOUR_WRAP    = 23;
    localparam int unsigned SEC_MAX      = 59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned val);
        bcd2_t r;
        r.tens  = 4'(val / 10);
        r.units = 4'(val % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at WRAP (59 or 23), with carry out and a
// synchronous load used for reset.
module bcd2_counter
    import cuckoo_pkg::*;
#(
    parameter int unsigned WRAP = 59
) (
    input  logic  i_clk,
    input  logic  i_load,
    input  bcd2_t i_load_val,
    input  logic  i_inc,
    output bcd2_t o_value,
    output logic  o_carry_out
);

    localparam logic [3:0] WRAP_TENS  = 4'(WRAP / 10);
    localparam logic [3:0] WRAP_UNITS = 4'(WRAP % 10);

    bcd2_t r_value;
    bcd2_t w_next;
    logic  w_at_wrap;
    logic  w_illegal;

    assign w_at_wrap = (r_value.tens == WRAP_TENS) && (r_value.units == WRAP_UNITS);
    assign w_illegal = (r_value.units > 4'd9) || (r_value.tens > WRAP_TENS) ||
                       ((r_value.tens == WRAP_TENS) && (r_value.units > WRAP_UNITS));

    // Fault-injected values fall back to 00 like a normal wrap, but without carry.
    always_comb begin
        w_next = r_value;
        if (w_illegal || w_at_wrap) begin
            w_next = '0;
        end else if (r_value.units == 4'd9) begin
            w_next.units = 4'd0;
            w_next.tens  = r_value.tens + 4'd1;
        end else begin
            w_next.units = r_value.units + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            r_value <= w_next;
        end
    end

    assign o_value     = r_value;
    assign o_carry_out = i_inc & w_at_wrap;

endmodule

// File: rtl/time_keeper.sv
// BCD HH:MM:SS time-of-day core with two-button set mode.
// Define CUCKOO_ALARM_EN to add the alarm register pair and SET_ALARM state.
module time_keeper
    import cuckoo_pkg::*;
#(
    parameter int unsigned RESET_HOUR = 0,
    parameter int unsigned RESET_MIN  = 0
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       sig1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] h_tens,
    output logic [3:0] h_units,
    output logic [3:0] m_tens,
    output logic [3:0] m_units,
    output logic [5:0] sec,
    output logic [1:0] set_mode
`ifdef CUCKOO_ALARM_EN
    ,
    input  logic       alarm_arm,
    output logic       alarm_active
`endif
);

    localparam bcd2_t RESET_HOUR_BCD = to_bcd2(RESET_HOUR);
    localparam bcd2_t RESET_MIN_BCD  = to_bcd2(RESET_MIN);

    logic   r_s1_prev;
    logic   r_mode_meta, r_mode_sync, r_mode_prev, r_mode_press;
    logic   r_inc_meta, r_inc_sync, r_inc_prev, r_inc_press;
    state_e r_state, w_state_next;
    logic [5:0] r_sec;

    logic  w_tick, w_mode_press, w_inc_press;
    logic  w_run_tick, w_leave_min, w_sec_carry;
    logic  w_min_inc, w_min_carry, w_hour_inc, w_hour_carry;
    bcd2_t w_min, w_hour;

    // Sync + edge detect; the registered press pulse lands on the 3rd edge
    // after the button is first sampled high.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_s1_prev    <= 1'b0;
            r_mode_meta  <= 1'b0;
            r_mode_sync  <= 1'b0;
            r_mode_prev  <= 1'b0;
            r_mode_press <= 1'b0;
            r_inc_meta   <= 1'b0;
            r_inc_sync   <= 1'b0;
            r_inc_prev   <= 1'b0;
            r_inc_press  <= 1'b0;
        end else begin
            r_s1_prev    <= sig1s;
            r_mode_meta  <= btn_mode;
            r_mode_sync  <= r_mode_meta;
            r_mode_prev  <= r_mode_sync;
            r_mode_press <= r_mode_sync & ~r_mode_prev;
            r_inc_meta   <= btn_inc;
            r_inc_sync   <= r_inc_meta;
            r_inc_prev   <= r_inc_sync;
            r_inc_press  <= r_inc_sync & ~r_inc_prev;
        end
    end

    assign w_tick       = sig1s & ~r_s1_prev;
    assign w_mode_press = r_mode_press;
    assign w_inc_press  = r_inc_press & ~r_mode_press;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_mode_press) begin
            case (r_state)
                StRun:     w_state_next = StSetHour;
                StSetHour: w_state_next = StSetMin;
`ifdef CUCKOO_ALARM_EN
                StSetMin:  w_state_next = StSetAlarm;
`else
                StSetMin:  w_state_next = StRun;
`endif
                default:   w_state_next = StRun;
            endcase
        end
    end

    assign w_run_tick  = w_tick & (r_state == StRun);
    assign w_leave_min = w_mode_press & (r_state == StSetMin);
    assign w_sec_carry = w_run_tick & (r_sec == 6'(SEC_MAX));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sec <= '0;
        end else if (w_leave_min) begin
            r_sec <= '0;
        end else if (w_run_tick) begin
            r_sec <= (r_sec >= 6'(SEC_MAX)) ? 6'd0 : r_sec + 6'd1;
        end
    end

    assign w_min_inc  = w_sec_carry | (w_inc_press & (r_state == StSetMin));
    // Minute wrap only carries into hours while running.
    assign w_hour_inc = (w_min_carry & (r_state == StRun)) |
                        (w_inc_press & (r_state == StSetHour));

    bcd2_counter #(
        .WRAP (MIN_WRAP)
    ) u_min (
        .i_clk       (sysclk),
        .i_load      (rst),
        .i_load_val  (RESET_MIN_BCD),
        .i_inc       (w_min_inc),
        .o_value     (w_min),
        .o_carry_out (w_min_carry)
    );

    bcd2_counter #(
        .WRAP (HOUR_WRAP)
    ) u_hour (
        .i_clk       (sysclk),
        .i_load      (rst),
        .i_load_val  (RESET_HOUR_BCD),
        .i_inc       (w_hour_inc),
        .o_value     (w_hour),
        .o_carry_out (w_hour_carry)
    );

`ifdef CUCKOO_ALARM_EN
    bcd2_t w_al_min, w_al_hour;
    logic  w_al_min_carry, w_al_hour_carry;
    logic  r_alarm_active;

    bcd2_counter #(
        .WRAP (MIN_WRAP)
    ) u_al_min (
        .i_clk       (sysclk),
        .i_load      (rst),
        .i_load_val  (to_bcd2(0)),
        .i_inc       (w_inc_press & (r_state == StSetAlarm)),
        .o_value     (w_al_min),
        .o_carry_out (w_al_min_carry)
    );

    bcd2_counter #(
        .WRAP (HOUR_WRAP)
    ) u_al_hour (
        .i_clk       (sysclk),
        .i_load      (rst),
        .i_load_val  (to_bcd2(6)),
        .i_inc       (w_al_min_carry),
        .o_value     (w_al_hour),
        .o_carry_out (w_al_hour_carry)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_alarm_active <= 1'b0;
        end else begin
            r_alarm_active <= (r_state == StRun) & alarm_arm &
                              ({w_hour, w_min} == {w_al_hour, w_al_min});
        end
    end

    assign alarm_active = r_alarm_active;
    assign {h_tens, h_units} = (r_state == StSetAlarm) ? w_al_hour : w_hour;
    assign {m_tens, m_units} = (r_state == StSetAlarm) ? w_al_min  : w_min;
`else
    assign {h_tens, h_units} = w_hour;
    assign {m_tens, m_units} = w_min;
`endif

    assign sec      = r_sec;
    assign set_mode = r_state;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- BCD time-of-day core for the cuckoo clock. Keeps HH:MM:SS in 24-hour format and advances on the 1 Hz square wave.
- Provides a two-button set mode and drives the four digit values consumed directly by the 4-digit 7-segment display stage: hour tens/units and minute tens/units.
- Sits immediately upstream of the display, replacing its hard-wired test digits.

Parameters:
- RESET_HOUR, 0, hour loaded on reset; binary 0..23, stored as BCD.
- RESET_MIN, 0, minute loaded on reset; binary 0..59, stored as BCD.

Ports:
- sysclk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sig1s  in  1  1 Hz square wave from the 1 s divider; the block edge-detects it internally
- btn_mode  in  1  debounced mode button, level, asynchronous to sysclk
- btn_inc  in  1  debounced increment button, level, asynchronous to sysclk
- h_tens  out  4  hour tens digit, BCD 0..2
- h_units  out  4  hour units digit, BCD 0..9
- m_tens  out  4  minute tens digit, BCD 0..5
- m_units  out  4  minute units digit, BCD 0..9
- sec  out  6  seconds, binary 0..59
- set_mode  out  2  00 = RUN, 01 = SET_HOUR, 10 = SET_MIN, 11 = SET_ALARM (only with ALARM_EN); the display uses it for blinking

Behaviour:
- Reset, synchronous, active-high:
  - time = RESET_HOUR:RESET_MIN:00; state RUN; set_mode = 00.
  - All edge-detect and synchroniser flops cleared.
  - Reset asserted mid-edit abandons the edit; it takes priority over every other event.
- Tick detection: register sig1s into s1_prev. A tick occurs on the edge where sig1s == 1 and s1_prev == 0. Exactly one tick per sig1s period.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detect.
  - An action occurs on the 3rd sysclk edge after the first edge that samples the button high.
  - Holding a button produces one action only; there is no auto-repeat.
- Outputs are registered. Every change is visible one cycle after the qualifying edge.
- RUN state:
  - On a tick, sec increments.
  - 59 -> 0 with carry into minutes. Minutes 59 -> 00 with carry into hours. Hours 23 -> 00.
  - Full rollover: 23:59:59 -> 00:00:00 on a single tick.
  - BCD per digit: units 9 -> 0 carries into tens; minute tens wrap at 5; hours wrap at 23, not 29.
- State machine: mode press advances RUN -> SET_HOUR -> SET_MIN -> RUN. With ALARM_EN the sequence continues SET_MIN -> SET_ALARM -> RUN.
- SET_HOUR: inc press adds 1 to hours, 23 -> 00, no carry. Ticks are ignored and time is frozen.
- SET_MIN: inc press adds 1 to minutes, 59 -> 00, no carry into hours. Ticks are ignored.
- Leaving SET_MIN (to RUN or SET_ALARM): sec is cleared to 0.
- Simultaneous events:
  - Tick and mode press on the same edge in RUN: the tick is applied and the state moves to SET_HOUR.
  - Mode and inc presses on the same edge: the mode press wins and inc is discarded.
  - A tick in a SET state is discarded, not deferred.
- Digit outputs never hold non-BCD values. Any illegal internal value, reachable only via fault, resolves to 00 on the next increment.

Optional Feature:
- Macro: CUCKOO_ALARM_EN.
- With the macro defined:
  - Adds an alarm register pair (BCD hour/minute, reset 06:00) and state SET_ALARM (set_mode = 11).
  - In SET_ALARM, inc advances alarm minutes; 59 -> 00 also increments alarm hours, 23 -> 00.
  - In SET_ALARM the digit outputs show the alarm time instead of the current time.
  - Adds input alarm_arm (1 bit) and output alarm_active (1 bit, reset 0).
  - alarm_active = 1 while state == RUN, alarm_arm == 1, and the current HH:MM equals the alarm HH:MM, i.e. for the whole matching minute. It is registered and deasserts the cycle after any condition drops.
- Without the macro: no alarm logic, no alarm ports, and mode cycles through three states only.

Decomposition:
- Shared package cuckoo_pkg holds:
  - state encodings RUN/SET_HOUR/SET_MIN/SET_ALARM as 2-bit constants;
  - BCD limit constants: MIN_TENS_MAX = 5, HOUR_WRAP = 23, SEC_MAX = 59.
- Natural sub-module bcd2_counter: a two-digit BCD counter with inc, carry_out, and parameterised wrap value (59 or 23), plus synchronous load for reset.
  - Instantiated for minutes, for hours, and for the alarm pair.

Test Plan:
- Reset with defaults -> digits 0,0,0,0, sec 0, set_mode 00, the cycle after rst deasserts.
- Preset to 23:59:58 and apply 2 rising edges of sig1s -> 23:59:59 then 00:00:00. h_tens goes 2 -> 0 on the same cycle as m_units 9 -> 0.
- Hold sig1s high for 1000 cycles -> exactly one sec increment.
- Mode once, then inc 25 times -> hours 00 -> 01; minutes and seconds unchanged. Ticks during SET_HOUR do not move sec.
- In SET_MIN at 12:59:30, press inc -> 12:00. Press mode -> RUN with sec = 0.
- Tick and mode press on the same edge at 10:15:07 -> 10:15:08 and set_mode 01. With CUCKOO_ALARM_EN: alarm 06:00, armed, time 05:59:59 + tick -> alarm_active 1; 60 ticks later -> 0.
